// File: rtl/scan_pkg.sv
// Shared types for the scan-chain initiator: FSM state encoding and the
// bit shifted into the chain while the response is unloaded.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    UNLOAD,
    FINISH
  } scan_state_e;

  localparam logic SCAN_FILL_BIT = 1'b0;

endpackage

// File: rtl/scan_shift_reg.sv
// Pattern PISO feeding the chain's scan-in, plus response SIPO collecting the
// chain's scan-out and a parallel response register committed at run end.
module scan_shift_reg
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [CHAIN_LEN-1:0] pat_i,
  input  logic                 shift_out_i,
  output logic                 next_bit_o,
  input  logic                 shift_in_i,
  input  logic                 so_i,
  input  logic                 commit_i,
  output logic [CHAIN_LEN-1:0] resp_o
);

  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic [CHAIN_LEN-1:0] cap_next;

  // First bit sampled lands in the MSB after CHAIN_LEN shifts.
  assign cap_next = {cap_q[CHAIN_LEN-2:0], so_i};

  always_comb begin
    pat_d  = pat_q;
    cap_d  = cap_q;
    resp_d = resp_q;
    if (load_i) begin
      pat_d = pat_i;
    end else if (shift_out_i) begin
      pat_d = {pat_q[CHAIN_LEN-2:0], SCAN_FILL_BIT};
    end
    if (shift_in_i) begin
      cap_d = cap_next;
    end
    if (commit_i) begin
      resp_d = cap_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pat_q  <= '0;
      cap_q  <= '0;
      resp_q <= '0;
    end else begin
      pat_q  <= pat_d;
      cap_q  <= cap_d;
      resp_q <= resp_d;
    end
  end

  // The MSB is already on SI, so the bit below it is the next one to present.
  assign next_bit_o = pat_q[CHAIN_LEN-2];
  assign resp_o     = resp_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan-test initiator: shifts a pattern into a mux-scan chain, captures once,
// then unloads the response and presents it in parallel with a DONE pulse.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] PAT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CHAIN_LEN - 1);

  scan_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             se_q, si_q, busy_q, done_q;

  logic load, shift_out, shift_in, commit, next_bit, cnt_last;

  assign cnt_last  = (cnt_q == CntLast);
  assign load      = (state_q == IDLE) && START && !ABORT;
  assign shift_out = (state_q == SHIFT) && !ABORT;
  assign shift_in  = (state_q == UNLOAD) && !ABORT;
  assign commit    = shift_in && cnt_last;

  scan_shift_reg #(
    .CHAIN_LEN(CHAIN_LEN)
  ) u_shift_reg (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (load),
    .pat_i      (PAT),
    .shift_out_i(shift_out),
    .next_bit_o (next_bit),
    .shift_in_i (shift_in),
    .so_i       (SO),
    .commit_i   (commit),
    .resp_o     (RESP)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && ABORT) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        se_q    <= 1'b0;
        si_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (load) begin
              state_q <= SHIFT;
              cnt_q   <= '0;
              se_q    <= 1'b1;
              si_q    <= PAT[CHAIN_LEN-1];
              busy_q  <= 1'b1;
            end
          end
          SHIFT: begin
            if (cnt_last) begin
              state_q <= CAPTURE;
              cnt_q   <= '0;
              se_q    <= 1'b0;
              si_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              si_q  <= next_bit;
            end
          end
          CAPTURE: begin
            state_q <= UNLOAD;
            cnt_q   <= '0;
            se_q    <= 1'b1;
            si_q    <= SCAN_FILL_BIT;
          end
          UNLOAD: begin
            if (cnt_last) begin
              state_q <= FINISH;
              cnt_q   <= '0;
              se_q    <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          FINISH: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SE   = se_q;
  assign SI   = si_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
